step_watchdog: RTL and testbench

- Parametrised per-channel step-activity watchdog. Each channel counts clocks since its last step edge and flags expiry when that count reaches a programmable timeout.
- When armed, an expiry on any mask-enabled channel raises a sticky shutdown request towards command.
- Instantiated in the top level between the stepper outputs and command's req_shutdown input.
- Replaces the fixed 6-channel, 10 s inline step watcher and adds runtime timeouts, masks, acknowledge and counter readback.

---
 rtl/step_watchdog.sv | 150 +++++++++++++++
 tb/tb_step_watchdog.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_watchdog.sv
// step_watchdog: per-channel step-activity watchdog with programmable
// timeouts, arm mask, sticky shutdown request and counter readback.
module step_watchdog #(
    parameter int                  NCH             = 6,
    parameter int                  CNT_BITS        = 32,
    parameter logic [CNT_BITS-1:0] DEFAULT_TIMEOUT = CNT_BITS'(480000000),
    parameter int                  CH_BITS         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      step,
    input  logic [NCH-1:0]      arm_mask,
    input  logic                arm_set,
    input  logic                disarm,
    input  logic                ack,
    input  logic                timeout_wr_en,
    input  logic [CH_BITS-1:0]  timeout_wr_ch,
    input  logic [CNT_BITS-1:0] timeout_wr_data,
    input  logic [CH_BITS-1:0]  rd_ch,
    output logic [CNT_BITS-1:0] rd_data,
    output logic [NCH-1:0]      expired,
    output logic [NCH-1:0]      alert,
    output logic [NCH-1:0]      alert_sticky,
    output logic                armed,
    output logic                req_shutdown
);

    logic [NCH-1:0]      r_prev_step;
    logic [CNT_BITS-1:0] r_cnt [NCH];
    logic [CNT_BITS-1:0] r_timeout [NCH];
    logic [NCH-1:0]      r_expired;
    logic [NCH-1:0]      r_expired_d;
    logic [NCH-1:0]      r_alert_sticky;
    logic                r_armed;
    logic                r_req_shutdown;
    logic [CNT_BITS-1:0] r_rd_data;

    logic [NCH-1:0]      w_edge;
    logic [NCH-1:0]      w_wr_hit;
    logic [NCH-1:0]      w_wr_zero;
    logic [NCH-1:0]      w_alert;
    logic                w_trip;
    logic [CNT_BITS-1:0] w_rd_sel;

    // Edge detect, write/readback channel decode; out-of-range selects match nothing.
    always_comb begin
        w_edge    = step ^ r_prev_step;
        w_wr_hit  = '0;
        w_wr_zero = '0;
        w_rd_sel  = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wr_hit[i]  = timeout_wr_en && (timeout_wr_ch == CH_BITS'(i));
            w_wr_zero[i] = w_wr_hit[i] && (timeout_wr_data == '0);
            if (rd_ch == CH_BITS'(i)) begin
                w_rd_sel = r_cnt[i];
            end
        end
        w_alert = r_expired & ~r_expired_d;
        w_trip  = r_armed && |(r_expired & arm_mask);
    end

    // Remember last step level and last expired level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_step <= '0;
            r_expired_d <= '0;
        end else begin
            r_prev_step <= step;
            r_expired_d <= r_expired;
        end
    end

    // Timeout registers; a write is used for comparison from the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_timeout[i] <= DEFAULT_TIMEOUT;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_hit[i]) begin
                    r_timeout[i] <= timeout_wr_data;
                end
            end
        end
    end

    // Idle counters saturate at the timeout; a zero write disables at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_expired <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_zero[i] || (r_timeout[i] == '0) || w_edge[i]) begin
                    r_cnt[i]     <= '0;
                    r_expired[i] <= 1'b0;
                end else if (r_cnt[i] >= r_timeout[i]) begin
                    r_expired[i] <= 1'b1;
                end else begin
                    r_cnt[i]     <= r_cnt[i] + CNT_BITS'(1);
                    r_expired[i] <= 1'b0;
                end
            end
        end
    end

    // Latch alerts until acknowledged; a new alert beats a simultaneous ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alert_sticky <= '0;
        end else begin
            r_alert_sticky <= (r_alert_sticky & ~{NCH{ack}}) | w_alert;
        end
    end

    // Arm state and sticky shutdown request; disarm never drops the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed        <= 1'b0;
            r_req_shutdown <= 1'b0;
        end else begin
            if (disarm) begin
                r_armed <= 1'b0;
            end else if (arm_set) begin
                r_armed <= 1'b1;
            end
            r_req_shutdown <= w_trip | (r_req_shutdown & ~ack);
        end
    end

    // Registered counter readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_sel;
        end
    end

    assign rd_data      = r_rd_data;
    assign expired      = r_expired;
    assign alert        = w_alert;
    assign alert_sticky = r_alert_sticky;
    assign armed        = r_armed;
    assign req_shutdown = r_req_shutdown;

endmodule

// File: tb/tb_step_watchdog.sv
// tb_step_watchdog: directed bench for step_watchdog with a short
// default timeout so expiry timing is reachable in simulation.
module tb_step_watchdog;

    localparam int NCH = 6;
    localparam int CNT_BITS = 32;
    localparam int CH_BITS = 3;

    logic                clk;
    logic                rst_n;
    logic [NCH-1:0]      step;
    logic [NCH-1:0]      arm_mask;
    logic                arm_set;
    logic                disarm;
    logic                ack;
    logic                timeout_wr_en;
    logic [CH_BITS-1:0]  timeout_wr_ch;
    logic [CNT_BITS-1:0] timeout_wr_data;
    logic [CH_BITS-1:0]  rd_ch;
    logic [CNT_BITS-1:0] rd_data;
    logic [NCH-1:0]      expired;
    logic [NCH-1:0]      alert;
    logic [NCH-1:0]      alert_sticky;
    logic                armed;
    logic                req_shutdown;

    int n_checks;
    int n_errors;

    step_watchdog #(
        .NCH(NCH),
        .CNT_BITS(CNT_BITS),
        .DEFAULT_TIMEOUT(32'd100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .step(step),
        .arm_mask(arm_mask),
        .arm_set(arm_set),
        .disarm(disarm),
        .ack(ack),
        .timeout_wr_en(timeout_wr_en),
        .timeout_wr_ch(timeout_wr_ch),
        .timeout_wr_data(timeout_wr_data),
        .rd_ch(rd_ch),
        .rd_data(rd_data),
        .expired(expired),
        .alert(alert),
        .alert_sticky(alert_sticky),
        .armed(armed),
        .req_shutdown(req_shutdown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exp"}, 32'(expired), 32'h0);
        check({tag, "_alert"}, 32'(alert), 32'h0);
        check({tag, "_sticky"}, 32'(alert_sticky), 32'h0);
        check({tag, "_armed"}, 32'(armed), 32'h0);
        check({tag, "_req"}, 32'(req_shutdown), 32'h0);
        check({tag, "_rd"}, rd_data, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        step = '0;
        arm_mask = '0;
        arm_set = 1'b0;
        disarm = 1'b0;
        ack = 1'b0;
        timeout_wr_en = 1'b0;
        timeout_wr_ch = '0;
        timeout_wr_data = '0;
        rd_ch = '0;

        // Reset state
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release: every channel expires at edge 101
        for (int k = 1; k <= 102; k++) begin
            tick();
            if (k == 50) check("p1_rd49", rd_data, 32'd49);
            if (k == 100) check("p1_exp100", 32'(expired), 32'h0);
            if (k == 101) begin
                check("p1_exp101", 32'(expired), 32'h3f);
                check("p1_alert101", 32'(alert), 32'h3f);
            end
            if (k == 102) begin
                check("p1_alert102", 32'(alert), 32'h0);
                check("p1_sticky", 32'(alert_sticky), 32'h3f);
                check("p1_req", 32'(req_shutdown), 32'h0);
            end
        end

        // Clear everything with a step on all channels plus ack, then arm
        step = step ^ 6'h3f;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("p2_clr_exp", 32'(expired), 32'h0);
        check("p2_clr_sticky", 32'(alert_sticky), 32'h0);
        arm_mask = 6'b100000;
        arm_set = 1'b1;
        tick();
        arm_set = 1'b0;
        check("p2_armed", 32'(armed), 32'h1);
        for (int cyc = 2; cyc <= 103; cyc++) begin
            tick();
            if (cyc == 100) check("p2_exp100", 32'(expired), 32'h0);
            if (cyc == 101) begin
                check("p2_exp101", 32'(expired), 32'h20);
                check("p2_req101", 32'(req_shutdown), 32'h0);
            end
            if (cyc == 102) begin
                check("p2_req102", 32'(req_shutdown), 32'h1);
                ack = 1'b1;
            end
            if (cyc == 103) begin
                check("p2_ack_held", 32'(req_shutdown), 32'h1);
                ack = 1'b0;
            end
            if (cyc % 10 == 0) step[4:0] = ~step[4:0];
        end

        // Step ch5, ack clears request and sticky, then arm+disarm together
        step[5] = ~step[5];
        tick();
        check("p3_exp5_clr", 32'(expired), 32'h0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("p3_req_clr", 32'(req_shutdown), 32'h0);
        check("p3_sticky_clr", 32'(alert_sticky), 32'h0);
        arm_set = 1'b1;
        disarm = 1'b1;
        tick();
        arm_set = 1'b0;
        disarm = 1'b0;
        check("p3_disarm_wins", 32'(armed), 32'h0);

        // Timeout write below current count, then disable with zero
        step = step ^ 6'h3f;
        rd_ch = 3'd2;
        tick();
        for (int k = 1; k <= 50; k++) tick();
        check("p4_rd49", rd_data, 32'd49);
        timeout_wr_en = 1'b1;
        timeout_wr_ch = 3'd2;
        timeout_wr_data = 32'd20;
        tick();
        timeout_wr_en = 1'b0;
        check("p4_exp_w", 32'(expired), 32'h0);
        tick();
        check("p4_exp_w1", 32'(expired), 32'h04);
        check("p4_alert_w1", 32'(alert), 32'h04);
        timeout_wr_en = 1'b1;
        timeout_wr_data = 32'd0;
        tick();
        timeout_wr_en = 1'b0;
        check("p4_zero_exp", 32'(expired), 32'h0);
        tick();
        check("p4_zero_rd", rd_data, 32'd0);
        timeout_wr_en = 1'b1;
        timeout_wr_ch = 3'd6;
        timeout_wr_data = 32'd5;
        tick();
        timeout_wr_ch = 3'd7;
        tick();
        timeout_wr_en = 1'b0;
        tick();
        tick();
        check("p4_oor_ignored", 32'(expired), 32'h0);
        check("p4_zero_hold", rd_data, 32'd0);

        // Step on ch1 in the cycle its count reaches the timeout
        step = step ^ 6'h3f;
        rd_ch = 3'd1;
        timeout_wr_en = 1'b1;
        timeout_wr_ch = 3'd1;
        timeout_wr_data = 32'd10;
        tick();
        timeout_wr_en = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        step[1] = ~step[1];
        tick();
        check("p5_rd10", rd_data, 32'd10);
        check("p5_exp1_a", 32'(expired[1]), 32'h0);
        tick();
        check("p5_rd0", rd_data, 32'd0);
        check("p5_exp1_b", 32'(expired[1]), 32'h0);
        check("p5_alert1", 32'(alert[1]), 32'h0);

        // Arm on ch1, wait (bounded) for the request, then async reset
        arm_mask = 6'b000010;
        arm_set = 1'b1;
        tick();
        arm_set = 1'b0;
        for (int k = 0; k < 30 && !req_shutdown; k++) tick();
        check("p6_req_set", 32'(req_shutdown), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        step = '0;
        arm_mask = '0;
        rd_ch = '0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            tick();
            if (k == 100) check("p6_exp100", 32'(expired), 32'h0);
            if (k == 101) check("p6_exp101", 32'(expired), 32'h3f);
        end
        check("p6_req_after", 32'(req_shutdown), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
